lcd_write_sequencer: RTL and testbench

- Downstream stage of the CPLD address decoder. It consumes the decoder's LCD select and the master's write strobe, and turns each master write into a correctly timed HD44780-style parallel write on the character LCD.
- It captures the bus byte and the RS select (address bit 0), then generates setup, E-pulse, hold and command-execution delays.
- It exposes a busy flag so the master can pace its writes.

---
 rtl/lcd_pkg.sv | 28 ++
 rtl/lcd_strobe_sync.sv | 31 +++
 rtl/lcd_write_sequencer.sv | 131 +++++++++++++
 tb/tb_lcd_write_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared types, command codes and default timing for the LCD write sequencer.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_EXEC  = 3'd4
  } lcd_state_t;

  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_HOME     = 8'h02;
  localparam logic [7:0] CMD_HOME_ALT = 8'h03;

  localparam int DEF_SETUP_CYC     = 2;
  localparam int DEF_PULSE_CYC     = 12;
  localparam int DEF_HOLD_CYC      = 2;
  localparam int DEF_EXEC_CYC      = 1000;
  localparam int DEF_LONG_EXEC_CYC = 40000;
  localparam int DEF_CNT_W         = 16;

  // Clear and return-home are the only instructions needing the long execution wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data == CMD_CLEAR || data == CMD_HOME || data == CMD_HOME_ALT);
  endfunction

endpackage

// File: rtl/lcd_strobe_sync.sv
// Two-flop synchronizer with reset preset and falling-edge detect on the synced value.
module lcd_strobe_sync
  import lcd_pkg::*;
#(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic fall
);

  logic meta;
  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
      prev <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
      prev <= q;
    end
  end

  assign fall = prev & ~q;

endmodule

// File: rtl/lcd_write_sequencer.sv
// Turns each decoded master write into a timed HD44780-style write cycle with busy pacing.
// state | meaning
// IDLE  | waiting for a strobe falling edge with the LCD addressed
// SETUP | data/RS driven, lcd_e low
// PULSE | lcd_e high
// HOLD  | lcd_e low, data/RS still held
// EXEC  | waiting for the LCD controller to finish the instruction
module lcd_write_sequencer
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC     = DEF_SETUP_CYC,
  parameter int PULSE_CYC     = DEF_PULSE_CYC,
  parameter int HOLD_CYC      = DEF_HOLD_CYC,
  parameter int EXEC_CYC      = DEF_EXEC_CYC,
  parameter int LONG_EXEC_CYC = DEF_LONG_EXEC_CYC,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       lcd_en,
  input  logic       rs_sel,
  input  logic [7:0] bus_in,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic       busy,
  output logic       overrun
);

  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] EXEC_LOAD  = CNT_W'(EXEC_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_LOAD  = CNT_W'(LONG_EXEC_CYC - 1);

  logic             enable_sync;
  logic             enable_fall;
  logic             lcd_en_meta;
  logic             lcd_en_sync;
  logic             write_req;
  lcd_state_t       state;
  logic [CNT_W-1:0] cnt;

  lcd_strobe_sync #(.RESET_VAL(1'b1)) u_enable_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (enable),
    .q     (enable_sync),
    .fall  (enable_fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lcd_en_meta <= 1'b1;
      lcd_en_sync <= 1'b1;
    end else begin
      lcd_en_meta <= lcd_en;
      lcd_en_sync <= lcd_en_meta;
    end
  end

  assign write_req = enable_fall & lcd_en_sync;
  assign lcd_rw    = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      lcd_data <= 8'h00;
      lcd_rs   <= 1'b0;
      lcd_e    <= 1'b0;
      busy     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      overrun <= write_req && (state != ST_IDLE);
      unique case (state)
        ST_IDLE: begin
          if (write_req) begin
            lcd_data <= bus_in;
            lcd_rs   <= rs_sel;
            cnt      <= SETUP_LOAD;
            busy     <= 1'b1;
            state    <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt == '0) begin
            cnt   <= PULSE_LOAD;
            lcd_e <= 1'b1;
            state <= ST_PULSE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_PULSE: begin
          if (cnt == '0) begin
            cnt   <= HOLD_LOAD;
            lcd_e <= 1'b0;
            state <= ST_HOLD;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_HOLD: begin
          if (cnt == '0) begin
            cnt   <= is_long_cmd(lcd_rs, lcd_data) ? LONG_LOAD : EXEC_LOAD;
            state <= ST_EXEC;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_EXEC: begin
          if (cnt == '0) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          lcd_e <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_write_sequencer.sv
// Scoreboard bench: stimulus pushes expected write sequences, a negedge monitor measures and compares them.
module tb_lcd_write_sequencer;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       lcd_en;
  logic       rs_sel;
  logic [7:0] bus_in;
  logic [7:0] lcd_data;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;
  logic       busy;
  logic       overrun;

  typedef struct {
    logic [7:0] data;
    logic       rs;
    int         blen;
    int         ovr;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  lcd_write_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .lcd_en   (lcd_en),
    .rs_sel   (rs_sel),
    .bus_in   (bus_in),
    .lcd_data (lcd_data),
    .lcd_rs   (lcd_rs),
    .lcd_rw   (lcd_rw),
    .lcd_e    (lcd_e),
    .busy     (busy),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Monitor: measures each busy window and checks it against the next queued expectation.
  logic       in_txn = 1'b0;
  logic       busy_q = 1'b0;
  logic       e_q = 1'b0;
  int         cyc, setup_obs, e_high, e_rises, ovr_cnt, blen_obs, changed;
  logic [7:0] d0;
  logic       rs0;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_txn = 1'b0;
      busy_q = 1'b0;
      e_q    = 1'b0;
    end else begin
      if (busy && !busy_q) begin
        in_txn = 1'b1; cyc = 0; setup_obs = -1; e_high = 0; e_rises = 0;
        ovr_cnt = 0; blen_obs = 0; changed = 0; d0 = lcd_data; rs0 = lcd_rs;
      end
      if (in_txn) begin
        if (busy) begin
          blen_obs++;
          if (lcd_data != d0 || lcd_rs != rs0) changed = 1;
        end
        if (lcd_e && !e_q) begin
          e_rises++;
          if (e_rises == 1) setup_obs = cyc;
        end
        if (lcd_e) e_high++;
        if (overrun) ovr_cnt++;
        cyc++;
        if (!busy) begin
          in_txn = 1'b0;
          if (sb_q.size() == 0) begin
            chk("unexpected_sequence", 1, 0);
          end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("seq_data", int'(d0), int'(e.data));
            chk("seq_rs", int'(rs0), int'(e.rs));
            chk("seq_busy_len", blen_obs, e.blen);
            chk("seq_setup_cyc", setup_obs, 2);
            chk("seq_e_high_cyc", e_high, 12);
            chk("seq_e_pulses", e_rises, 1);
            chk("seq_overrun_cnt", ovr_cnt, e.ovr);
            chk("seq_outputs_stable", changed, 0);
          end
        end
      end
      busy_q = busy;
      e_q    = lcd_e;
    end
  end

  // Caller must be at a negedge; drives the strobe low and checks the capture 3 edges later.
  task automatic do_write(input logic [7:0] d, input logic rs, input int blen,
                          input int ovr, input bit push);
    bus_in = d;
    rs_sel = rs;
    lcd_en = 1'b1;
    enable = 1'b0;
    if (push) sb_q.push_back('{d, rs, blen, ovr});
    repeat (3) @(posedge clk);
    #1;
    chk("capture_data", int'(lcd_data), int'(d));
    chk("capture_rs", int'(lcd_rs), int'(rs));
    chk("capture_busy", int'(busy), 1);
    @(negedge clk);
    enable = 1'b1;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 45000 && sb_q.size() != 0; i++) @(negedge clk);
    chk("drain_pending", sb_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int seen;
    rst_n  = 1'b0;
    enable = 1'b1;
    lcd_en = 1'b0;
    rs_sel = 1'b0;
    bus_in = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_lcd_data", int'(lcd_data), 0);
    chk("rst_lcd_rs", int'(lcd_rs), 0);
    chk("rst_lcd_e", int'(lcd_e), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_lcd_rw", int'(lcd_rw), 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Data write 'A': 2+12+2+1000
    do_write(8'h41, 1'b1, 1016, 0, 1'b1);
    wait_drain();
    // Clear display: long exec
    do_write(8'h01, 1'b0, 40016, 0, 1'b1);
    wait_drain();
    // Data byte 0x01 uses normal exec
    do_write(8'h01, 1'b1, 1016, 0, 1'b1);
    wait_drain();
    // Command 0x04 is just past the long-exec range
    do_write(8'h04, 1'b0, 1016, 0, 1'b1);
    wait_drain();

    // Overrun: second strobe 50 cycles into the first sequence
    do_write(8'h55, 1'b1, 1016, 1, 1'b1);
    repeat (49) @(negedge clk);
    bus_in = 8'h66;
    rs_sel = 1'b0;
    enable = 1'b0;
    repeat (5) @(negedge clk);
    enable = 1'b1;
    chk("overrun_data_kept", int'(lcd_data), 8'h55);
    chk("overrun_rs_kept", int'(lcd_rs), 1);
    wait_drain();

    // Strobe with LCD not addressed
    lcd_en = 1'b0;
    bus_in = 8'h77;
    repeat (4) @(negedge clk);
    enable = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (lcd_e || busy || overrun) seen = 1;
    end
    chk("unaddressed_activity", seen, 0);
    enable = 1'b1;
    repeat (4) @(negedge clk);

    // Back-to-back: second strobe recognised in the single IDLE cycle
    do_write(8'h48, 1'b0, 1016, 0, 1'b1);
    repeat (1014) @(negedge clk);
    do_write(8'h49, 1'b1, 1016, 0, 1'b1);
    wait_drain();

    // Reset during the E pulse
    do_write(8'h30, 1'b1, 0, 0, 1'b0);
    seen = 0;
    for (int i = 0; i < 20 && !lcd_e; i++) @(negedge clk);
    chk("midpulse_e_reached", int'(lcd_e), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midpulse_e_async_low", int'(lcd_e), 0);
    chk("midpulse_busy", int'(busy), 0);
    chk("midpulse_data", int'(lcd_data), 0);
    chk("midpulse_rs", int'(lcd_rs), 0);
    chk("midpulse_overrun", int'(overrun), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (lcd_e || busy || overrun) seen = 1;
    end
    chk("post_reset_no_resume", seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
